sr_trace_buffer: RTL and testbench
==================================

# sr_trace_buffer

Synthesizable on-chip instruction trace recorder for the schoolRISCV core, the hardware successor to the simulation-only cycle printer. It sits beside `sm_cpu` in `sm_top`, samples `pc`, `instr` and `a0` on every CPU-clock-enabled cycle into a parametrised ring buffer, and freezes on a PC trigger, a post-trigger count or a timeout. Debug logic or a board host then reads the frozen history back entry by entry, without a simulator.

## Interface
- `DEPTH_LOG2`, 4: ring holds 2^DEPTH_LOG2 entries.
- `POST`, 8: entries recorded after the trigger entry. Range 0..2^DEPTH_LOG2-1.
- `TIMEOUT`, 120: samples after arm before forced stop. 0 disables the timeout.
- `clk` in 1: single clock. All logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_valid` in 1: sample strobe, i.e. the CPU clock enable for the cycle.
- `cpu_pc` in 32: current PC.
- `cpu_instr` in 32: current instruction word.
- `cpu_a0` in 32: value of register x10.
- `trig_pc` in 32: trigger PC. Present only with `SR_TRACE_TRIGGER_EN`.
- `arm` in 1: single-cycle pulse that clears and (re)starts recording.
- `rd_idx` in DEPTH_LOG2: read index. 0 is the oldest valid entry.
- `rd_sel` in 2: field select. 0 = pc, 1 = instr, 2 = a0, 3 = sample stamp.
- `rd_data` out 32: registered read data.
- `count` out DEPTH_LOG2+1: number of valid entries, saturating at 2^DEPTH_LOG2.
- `stamp` out 32: samples taken since arm.
- `state` out 2: current FSM state. IDLE = 0, ARMED = 1, CAPTURE = 2, DONE = 3.
- `timeout` out 1: DONE was reached by timeout.

## Operation
- Entry format: {pc, instr, a0, stamp}, 128 bits. Storage is a 2^DEPTH_LOG2 × 128 register array.
- Write pointer `wp` wraps modulo depth. When full, each new sample overwrites the oldest entry.
- IDLE: nothing is recorded. `arm` moves to ARMED.
- ARMED: every `cpu_valid` sample is written at `wp`, then `wp++`, `count` saturating increment, `stamp++`. Trigger is `cpu_valid && cpu_pc == trig_pc`. The trigger sample is written, then the FSM moves to CAPTURE with post counter = POST.
- CAPTURE: each valid sample is written and decrements the post counter. When the counter is 0, the next state is DONE. With POST = 0, a trigger goes directly from ARMED to DONE.
- Timeout: `TIMEOUT` ≠ 0, state is ARMED or CAPTURE, and `stamp` reaches `TIMEOUT` after an increment. The FSM goes to DONE and sets `timeout` = 1. That sample is still recorded.
- DONE: buffer is frozen. Only `arm` leaves DONE.
- `arm` in any state: clears `count`, `stamp`, `timeout` and `wp`, and goes to ARMED. If `arm` and `cpu_valid` occur in the same cycle, `arm` wins and the sample is dropped.
- Trigger and timeout in the same sample: trigger entry is written, FSM goes to DONE with `timeout` = 1.
- Read address: physical index = (wp − count + rd_idx) mod depth. If rd_idx ≥ count, `rd_data` = 0. Reads are legal in every state; DONE gives stable data.
- Arithmetic: `stamp` is 32-bit and wraps; `count` saturates.

## Timing
- Reset values: `state` = IDLE, `count` = 0, `stamp` = 0, `timeout` = 0, `rd_data` = 0, `wp` = 0, post counter = 0. The buffer array is not reset.
- Capture: a sample at edge N is visible to reads from edge N+1. `count`, `stamp` and `state` update at edge N.
- Read latency: 1 cycle. `rd_idx` and `rd_sel` sampled at edge N produce `rd_data` after edge N.
- Reset asserted mid-capture: returns to IDLE immediately. Buffer contents are undefined to readers because `count` = 0.

## Configuration
- `SR_TRACE_TRIGGER_EN` defined: `trig_pc` port and the comparator exist, and ARMED keeps pre-trigger history as described in Operation.
- `SR_TRACE_TRIGGER_EN` undefined: `trig_pc` port is absent. The first valid sample after `arm` is the trigger: it is written, and the FSM enters CAPTURE (or DONE when POST = 0). This records exactly POST+1 entries, or fewer on timeout.

## Test plan
- Pulse `arm`, then 5 valid samples with pc 0x00, 0x04, … 0x10, no trigger match -> `count` = 5, `state` = 1; reading `rd_idx` = 0, `rd_sel` = 0 returns 0x00; `rd_idx` = 4 returns 0x10; `rd_idx` = 5 returns 0.
- DEPTH_LOG2 = 4, POST = 3, `trig_pc` = 0x80, PCs 0x00..0xFC step 4 -> `state` = 3 after the sample with pc 0x8C; `count` = 16; oldest entry pc = 0x50; newest entry pc = 0x8C; `timeout` = 0.
- TIMEOUT = 10, trigger never matches -> `state` = 3, `timeout` = 1, `stamp` = 10, `count` = 10; entry 9 has stamp 10.
- `arm` asserted together with `cpu_valid` while in DONE -> that sample is not recorded; `count` = 0, `stamp` = 0, `timeout` = 0, `state` = 1.
- Drive `rst_n` low during CAPTURE -> all outputs return to reset values immediately, and nothing is recorded until the next `arm`.
- Build without `SR_TRACE_TRIGGER_EN`, POST = 2, arm, then 6 samples -> `state` = 3 after the third sample; `count` = 3; entry pcs match the first three samples.

Source files
------------

// File: rtl/sr_trace_buffer.sv
// sr_trace_buffer: on-chip instruction trace recorder for the schoolRISCV core.
// It samples {pc, instr, a0, stamp} on every CPU-enabled cycle into a ring of
// 2^DEPTH_LOG2 entries. Recording freezes on a trigger, once the post-trigger
// count is used up, or on a timeout. The frozen history is then read back one
// entry at a time through rd_idx/rd_sel, with rd_idx 0 being the oldest entry.
//
// Optional feature macro: SR_TRACE_TRIGGER_EN
//   defined   : trig_pc port and PC comparator present; ARMED keeps pre-trigger
//               history in the ring until cpu_pc == trig_pc.
//   undefined : the first valid sample after arm acts as the trigger, so the
//               ring records POST+1 entries (fewer if the timeout fires).
module sr_trace_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned POST       = 8,
    parameter int unsigned TIMEOUT    = 120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    input  logic [31:0]           cpu_pc,
    input  logic [31:0]           cpu_instr,
    input  logic [31:0]           cpu_a0,
`ifdef SR_TRACE_TRIGGER_EN
    input  logic [31:0]           trig_pc,
`endif
    input  logic                  arm,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    input  logic [1:0]            rd_sel,
    output logic [31:0]           rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic [31:0]           stamp,
    output logic [1:0]            state,
    output logic                  timeout
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // Typed constants keep every arithmetic operand at the width of its target.
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST);
    localparam logic [31:0]           TIMEOUT_W = 32'(TIMEOUT);
    localparam bit                    TIMEOUT_ON = (TIMEOUT != 0);
    localparam bit                    POST_ZERO  = (POST == 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e                state_q,   state_d;
    logic [DEPTH_LOG2-1:0] wp_q,      wp_d;
    logic [DEPTH_LOG2:0]   count_q,   count_d;
    logic [31:0]           stamp_q,   stamp_d;
    logic [DEPTH_LOG2-1:0] post_q,    post_d;
    logic                  timeout_q, timeout_d;
    logic [31:0]           rd_data_q, rd_data_d;

    // Trace storage: one 128-bit entry per sample, not reset.
    logic [127:0]          mem_q [DEPTH];

    logic                  wr_en;
    logic [127:0]          wr_data;
    logic [31:0]           stamp_inc;
    logic                  trig_hit;
    logic                  timeout_hit;
    logic                  recording;

    // The stamp stored with an entry is the post-increment value, so the
    // first sample after arm carries stamp 1 and the timeout sample carries
    // exactly TIMEOUT.
    assign stamp_inc   = stamp_q + 32'd1;
    assign timeout_hit = TIMEOUT_ON && (stamp_inc == TIMEOUT_W);
    assign recording   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign wr_data     = {cpu_pc, cpu_instr, cpu_a0, stamp_inc};

`ifdef SR_TRACE_TRIGGER_EN
    assign trig_hit = (cpu_pc == trig_pc);
`else
    // Without a comparator the first sample taken while ARMED is the trigger.
    assign trig_hit = 1'b1;
`endif

    // State register and counters; asynchronous reset returns to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wp_q      <= '0;
            count_q   <= '0;
            stamp_q   <= '0;
            post_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            count_q   <= count_d;
            stamp_q   <= stamp_d;
            post_q    <= post_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: arm has priority over any sample in the same cycle.
    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        count_d   = count_q;
        stamp_d   = stamp_q;
        post_d    = post_q;
        timeout_d = timeout_q;
        wr_en     = 1'b0;

        if (arm) begin
            state_d   = ST_ARMED;
            wp_d      = '0;
            count_d   = '0;
            stamp_d   = '0;
            post_d    = '0;
            timeout_d = 1'b0;
        end else if (cpu_valid && recording) begin
            wr_en   = 1'b1;
            wp_d    = wp_q + PTR_ONE;
            stamp_d = stamp_inc;
            // The MSB of count is set only when the ring is exactly full.
            if (!count_q[DEPTH_LOG2]) begin
                count_d = count_q + CNT_ONE;
            end

            if (state_q == ST_ARMED) begin
                if (trig_hit) begin
                    if (POST_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                        post_d  = POST_INIT;
                    end
                end
            end else begin
                // CAPTURE: this sample uses one post-trigger slot; the last
                // slot takes the FSM to DONE.
                post_d = post_q - PTR_ONE;
                if (post_q <= PTR_ONE) begin
                    state_d = ST_DONE;
                end
            end

            // Timeout overrides the trigger path but the sample is kept.
            if (timeout_hit) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
            end
        end
    end

    // Trace RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read path: logical index 0 is the oldest valid entry.
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] rd_phys;
    logic                  rd_hit;
    logic [127:0]          rd_entry;
    logic [31:0]           rd_field [4];

    // Subtracting the low bits of count is enough: a full ring (count = DEPTH)
    // has zero low bits, so the oldest entry sits at wp itself.
    assign rd_phys  = wp_q - count_q[DEPTH_LOG2-1:0] + rd_idx;
    assign rd_hit   = ({1'b0, rd_idx} < count_q);
    assign rd_entry = mem_q[rd_phys];

    // Field order within an entry: pc (sel 0) in the top word down to the
    // stamp (sel 3) in the bottom word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_field
            assign rd_field[gi] = rd_entry[127 - 32*gi -: 32];
        end
    endgenerate

    // Indices beyond the valid history read as zero rather than stale data.
    always_comb begin
        rd_data_d = '0;
        if (rd_hit) begin
            rd_data_d = rd_field[rd_sel];
        end
    end

    // Registered read data, one cycle after rd_idx/rd_sel are sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign stamp   = stamp_q;
    assign state   = state_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Directed bench for sr_trace_buffer. Three instances share the CPU-side
// stimulus and differ only in POST/TIMEOUT:
//   a: POST 2 (3 with the trigger comparator), no timeout
//   b: POST 15, TIMEOUT 10 (timeout ends recording)
//   c: POST 4, TIMEOUT 1 (trigger and timeout on the same first sample)
module tb_sr_trace_buffer;

`ifdef SR_TRACE_TRIGGER_EN
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam int         POST_A = 3;
`else
    localparam logic [1:0] ST_RUN = 2'd2;
    localparam int         POST_A = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        cpu_valid;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic [31:0] cpu_a0;
    logic        arm;
    logic [3:0]  rd_idx;
    logic [1:0]  rd_sel;
`ifdef SR_TRACE_TRIGGER_EN
    logic [31:0] trig_pc;
`endif

    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic [4:0]  count_a,   count_b,   count_c;
    logic [31:0] stamp_a,   stamp_b,   stamp_c;
    logic [1:0]  state_a,   state_b,   state_c;
    logic        timeout_a, timeout_b, timeout_c;

    int n_cmp = 0;
    int n_bad = 0;

    sr_trace_buffer #(.DEPTH_LOG2(4), .POST(POST_A), .TIMEOUT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_pc(cpu_pc),
        .cpu_instr(cpu_instr), .cpu_a0(cpu_a0),
`ifdef SR_TRACE_TRIGGER_EN
        .trig_pc(trig_pc),
`endif
        .arm(arm), .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data_a),
        .count(count_a), .stamp(stamp_a), .state(state_a), .timeout(timeout_a)
    );

    sr_trace_buffer #(.DEPTH_LOG2(4), .POST(15), .TIMEOUT(10)) u_b (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_pc(cpu_pc),
        .cpu_instr(cpu_instr), .cpu_a0(cpu_a0),
`ifdef SR_TRACE_TRIGGER_EN
        .trig_pc(trig_pc),
`endif
        .arm(arm), .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data_b),
        .count(count_b), .stamp(stamp_b), .state(state_b), .timeout(timeout_b)
    );

    sr_trace_buffer #(.DEPTH_LOG2(4), .POST(4), .TIMEOUT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_pc(cpu_pc),
        .cpu_instr(cpu_instr), .cpu_a0(cpu_a0),
`ifdef SR_TRACE_TRIGGER_EN
        .trig_pc(trig_pc),
`endif
        .arm(arm), .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data_c),
        .count(count_c), .stamp(stamp_c), .state(state_c), .timeout(timeout_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  st_a;
        logic [4:0]  cnt_a;
        logic [1:0]  st_b;
        logic [4:0]  cnt_b;
        logic [31:0] stp_b;
        logic        to_b;
        logic [1:0]  st_c;
        logic [4:0]  cnt_c;
        logic        to_c;
    } step_t;

    typedef struct {
        logic [3:0]  idx;
        logic [1:0]  sel;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_c;
    } read_t;

    step_t steps [13];
    read_t reads [12];

    function automatic step_t mk(input logic a, input logic v, input logic [31:0] pc,
                                 input logic [1:0] sa, input logic [4:0] ca,
                                 input logic [1:0] sb, input logic [4:0] cb,
                                 input logic [31:0] tb, input logic ob,
                                 input logic [1:0] sc, input logic [4:0] cc,
                                 input logic oc);
        step_t s;
        s.arm = a;   s.valid = v;  s.pc = pc;
        s.st_a = sa; s.cnt_a = ca;
        s.st_b = sb; s.cnt_b = cb; s.stp_b = tb; s.to_b = ob;
        s.st_c = sc; s.cnt_c = cc; s.to_c = oc;
        return s;
    endfunction

    function automatic read_t mr(input logic [3:0] idx, input logic [1:0] sel,
                                 input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] ec);
        read_t r;
        r.idx = idx; r.sel = sel; r.exp_a = ea; r.exp_b = eb; r.exp_c = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // One CPU-side cycle: drive at the falling edge, observe 1 ns after the rise.
    task automatic step(input logic a, input logic v, input logic [31:0] pc);
        @(negedge clk);
        arm       = a;
        cpu_valid = v;
        cpu_pc    = pc;
        cpu_instr = {16'hC0DE, pc[15:0]};
        cpu_a0    = ~pc;
        @(posedge clk);
        #1;
        arm       = 1'b0;
        cpu_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [1:0] sel);
        @(negedge clk);
        rd_idx = idx;
        rd_sel = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        arm       = 1'b0;
        cpu_valid = 1'b0;
        cpu_pc    = '0;
        cpu_instr = '0;
        cpu_a0    = '0;
        rd_idx    = '0;
        rd_sel    = '0;
`ifdef SR_TRACE_TRIGGER_EN
        trig_pc   = 32'h80;
`endif

        // Sample stream: arm, then PCs 0x00.. step 4 with one idle cycle.
        //               arm v  pc      st_a cnt_a  st_b   cnt_b stp_b to_b  st_c cnt_c to_c
        steps[0]  = mk(1, 0, 32'h00, 1, 0,   1,      0,  0,  0,   1, 0, 0);
        steps[1]  = mk(0, 1, 32'h00, 2, 1,   ST_RUN, 1,  1,  0,   3, 1, 1);
        steps[2]  = mk(0, 1, 32'h04, 2, 2,   ST_RUN, 2,  2,  0,   3, 1, 1);
        steps[3]  = mk(0, 1, 32'h08, 3, 3,   ST_RUN, 3,  3,  0,   3, 1, 1);
        steps[4]  = mk(0, 1, 32'h0C, 3, 3,   ST_RUN, 4,  4,  0,   3, 1, 1);
        steps[5]  = mk(0, 0, 32'h0C, 3, 3,   ST_RUN, 4,  4,  0,   3, 1, 1);
        steps[6]  = mk(0, 1, 32'h10, 3, 3,   ST_RUN, 5,  5,  0,   3, 1, 1);
        steps[7]  = mk(0, 1, 32'h14, 3, 3,   ST_RUN, 6,  6,  0,   3, 1, 1);
        steps[8]  = mk(0, 1, 32'h18, 3, 3,   ST_RUN, 7,  7,  0,   3, 1, 1);
        steps[9]  = mk(0, 1, 32'h1C, 3, 3,   ST_RUN, 8,  8,  0,   3, 1, 1);
        steps[10] = mk(0, 1, 32'h20, 3, 3,   ST_RUN, 9,  9,  0,   3, 1, 1);
        steps[11] = mk(0, 1, 32'h24, 3, 3,   3,      10, 10, 1,   3, 1, 1);
        steps[12] = mk(0, 1, 32'h28, 3, 3,   3,      10, 10, 1,   3, 1, 1);

        // Read-back of the frozen buffers (a holds pcs 0,4,8; b holds 0..0x24).
        reads[0]  = mr(4'd0,  2'd0, 32'h0,        32'h0,        32'h0);
        reads[1]  = mr(4'd4,  2'd0, 32'h0,        32'h10,       32'h0);
        reads[2]  = mr(4'd9,  2'd0, 32'h0,        32'h24,       32'h0);
        reads[3]  = mr(4'd9,  2'd3, 32'h0,        32'd10,       32'h0);
        reads[4]  = mr(4'd10, 2'd0, 32'h0,        32'h0,        32'h0);
        reads[5]  = mr(4'd1,  2'd1, 32'hC0DE0004, 32'hC0DE0004, 32'h0);
        reads[6]  = mr(4'd2,  2'd2, 32'hFFFFFFF7, 32'hFFFFFFF7, 32'h0);
        reads[7]  = mr(4'd2,  2'd0, 32'h8,        32'h8,        32'h0);
        reads[8]  = mr(4'd2,  2'd3, 32'd3,        32'd3,        32'h0);
        reads[9]  = mr(4'd0,  2'd3, 32'd1,        32'd1,        32'd1);
        reads[10] = mr(4'd0,  2'd1, 32'hC0DE0000, 32'hC0DE0000, 32'hC0DE0000);
        reads[11] = mr(4'd15, 2'd3, 32'h0,        32'h0,        32'h0);

        // Reset values while reset is held.
        @(posedge clk);
        #1;
        chk("rst state_a",   32'(state_a),   32'd0);
        chk("rst count_a",   32'(count_a),   32'd0);
        chk("rst stamp_a",   stamp_a,        32'd0);
        chk("rst timeout_a", 32'(timeout_a), 32'd0);
        chk("rst rd_data_a", rd_data_a,      32'd0);
        chk("rst state_b",   32'(state_b),   32'd0);
        chk("rst rd_data_b", rd_data_b,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores samples until armed.
        step(1'b0, 1'b1, 32'h100);
        chk("idle state_a", 32'(state_a), 32'd0);
        chk("idle count_a", 32'(count_a), 32'd0);

        for (int i = 0; i < 13; i++) begin
            step(steps[i].arm, steps[i].valid, steps[i].pc);
`ifndef SR_TRACE_TRIGGER_EN
            chk($sformatf("step%0d state_a", i), 32'(state_a), 32'(steps[i].st_a));
            chk($sformatf("step%0d count_a", i), 32'(count_a), 32'(steps[i].cnt_a));
`endif
            chk($sformatf("step%0d state_b", i),   32'(state_b),   32'(steps[i].st_b));
            chk($sformatf("step%0d count_b", i),   32'(count_b),   32'(steps[i].cnt_b));
            chk($sformatf("step%0d stamp_b", i),   stamp_b,        steps[i].stp_b);
            chk($sformatf("step%0d timeout_b", i), 32'(timeout_b), 32'(steps[i].to_b));
            chk($sformatf("step%0d state_c", i),   32'(state_c),   32'(steps[i].st_c));
            chk($sformatf("step%0d count_c", i),   32'(count_c),   32'(steps[i].cnt_c));
            chk($sformatf("step%0d timeout_c", i), 32'(timeout_c), 32'(steps[i].to_c));
        end

        for (int i = 0; i < 12; i++) begin
            rd(reads[i].idx, reads[i].sel);
`ifndef SR_TRACE_TRIGGER_EN
            chk($sformatf("read%0d rd_data_a", i), rd_data_a, reads[i].exp_a);
`endif
            chk($sformatf("read%0d rd_data_b", i), rd_data_b, reads[i].exp_b);
            chk($sformatf("read%0d rd_data_c", i), rd_data_c, reads[i].exp_c);
        end

        // arm together with a valid sample in DONE: arm wins, sample dropped.
        step(1'b1, 1'b1, 32'h40);
        chk("armdone state_b",   32'(state_b),   32'd1);
        chk("armdone count_b",   32'(count_b),   32'd0);
        chk("armdone stamp_b",   stamp_b,        32'd0);
        chk("armdone timeout_b", 32'(timeout_b), 32'd0);
        chk("armdone timeout_c", 32'(timeout_c), 32'd0);
        chk("armdone count_a",   32'(count_a),   32'd0);
        step(1'b0, 1'b1, 32'h44);
        chk("post-arm state_a",   32'(state_a),   32'(ST_RUN));
        chk("post-arm count_a",   32'(count_a),   32'd1);
        chk("post-arm stamp_b",   stamp_b,        32'd1);
        chk("post-arm timeout_a", 32'(timeout_a), 32'd0);
        rd(4'd0, 2'd0);
        chk("post-arm entry0 pc_a", rd_data_a, 32'h44);
        step(1'b0, 1'b1, 32'h48);
        chk("pre-reset count_a", 32'(count_a), 32'd2);

        // Asynchronous reset in the middle of a recording.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async rst state_a",   32'(state_a),   32'd0);
        chk("async rst count_a",   32'(count_a),   32'd0);
        chk("async rst stamp_a",   stamp_a,        32'd0);
        chk("async rst rd_data_a", rd_data_a,      32'd0);
        chk("async rst state_b",   32'(state_b),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 32'h4C);
        step(1'b0, 1'b1, 32'h4C);
        chk("after rst state_a", 32'(state_a), 32'd0);
        chk("after rst count_a", 32'(count_a), 32'd0);
        chk("after rst stamp_a", stamp_a,      32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("rearm state_a", 32'(state_a), 32'd1);
        step(1'b0, 1'b1, 32'h50);
        chk("rearm count_a", 32'(count_a), 32'd1);
        rd(4'd0, 2'd0);
        chk("rearm entry0 pc_a", rd_data_a, 32'h50);
        rd(4'd1, 2'd0);
        chk("rearm entry1 pc_a", rd_data_a, 32'h0);

`ifdef SR_TRACE_TRIGGER_EN
        // Trigger at 0x80 with POST 3: ring keeps 12 pre-trigger entries.
        step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 32'(i * 4));
            if (cpu_pc == 32'h88) chk("trig state@0x88", 32'(state_a), 32'd2);
            if (cpu_pc == 32'h8C) chk("trig state@0x8C", 32'(state_a), 32'd3);
        end
        chk("trig count_a",   32'(count_a),   32'd16);
        chk("trig timeout_a", 32'(timeout_a), 32'd0);
        chk("trig state_a",   32'(state_a),   32'd3);
        rd(4'd0, 2'd0);
        chk("trig oldest pc", rd_data_a, 32'h50);
        rd(4'd15, 2'd0);
        chk("trig newest pc", rd_data_a, 32'h8C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
